// File: rtl/mem_bist.sv
// mem_bist: writes an address-derived pattern to every memory word, reads it back and counts mismatches.
// Define MEM_BIST_INV_PASS_EN for a second write/read pass with the inverted pattern.
module mem_bist #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 8,
   parameter logic [DWIDTH-1:0] SEED = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [AWIDTH:0]   err_count,
   output logic [AWIDTH-1:0] first_fail_addr,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [AWIDTH-1:0] mem_addr,
   inout  wire  [DWIDTH-1:0] mem_data
);
   typedef enum logic [2:0] {IDLE, WRITE, READ, TAIL, FIN} state_t;
   localparam logic [AWIDTH-1:0] LAST = '1;
   localparam logic [AWIDTH:0] SAT = '1;
   state_t state, state_nx;
   logic [AWIDTH-1:0] addr, addr_nx, cmp_addr;
   logic [DWIDTH-1:0] wdata;
   logic cmp, miss, again, inv, inv_nx;

   function automatic logic [DWIDTH-1:0] pattern(input logic [AWIDTH-1:0] a, input logic i);
      return DWIDTH'(a) ^ SEED ^ {DWIDTH{i}};
   endfunction

`ifdef MEM_BIST_INV_PASS_EN
   assign inv_nx = (state == IDLE) ? 1'b0 : (state == TAIL) ? 1'b1 : inv;
   assign again = !inv;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) inv <= 1'b0;
      else inv <= inv_nx;
`else
   assign inv = 1'b0;
   assign inv_nx = 1'b0;
   assign again = 1'b0;
`endif

   // read data lags the address by one cycle; TAIL holds the last address to catch its word
   assign cmp = (state == READ && addr != '0) || state == TAIL;
   assign cmp_addr = (state == TAIL) ? addr : addr - 1'b1;
   assign miss = cmp && mem_data != pattern(cmp_addr, inv);
   assign mem_addr = addr;
   assign mem_data = mem_wr ? wdata : {DWIDTH{1'bz}};

   always_comb begin
      state_nx = state;
      addr_nx = addr;
      case (state)
         IDLE: begin
            state_nx = start ? WRITE : IDLE;
            addr_nx = '0;
         end
         WRITE: begin
            addr_nx = addr + 1'b1;
            state_nx = (addr == LAST) ? READ : WRITE;
         end
         READ: begin
            addr_nx = (addr == LAST) ? addr : addr + 1'b1;
            state_nx = (addr == LAST) ? TAIL : READ;
         end
         TAIL: begin
            addr_nx = '0;
            state_nx = again ? WRITE : FIN;
         end
         default: begin
            addr_nx = '0;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         addr <= '0;
         wdata <= '0;
         mem_wr <= 1'b0;
         mem_rd <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
         err_count <= '0;
         first_fail_addr <= '0;
      end else begin
         state <= state_nx;
         addr <= addr_nx;
         wdata <= pattern(addr_nx, inv_nx);
         mem_wr <= state_nx == WRITE;
         mem_rd <= state_nx == READ || state_nx == TAIL;
         busy <= state_nx != IDLE;
         if (state == IDLE && start) begin
            done <= 1'b0;
            pass <= 1'b0;
            err_count <= '0;
            first_fail_addr <= '0;
         end else if (state == FIN) begin
            done <= 1'b1;
            pass <= err_count == '0;
         end else if (miss) begin
            if (err_count == '0) first_fail_addr <= cmp_addr;
            if (err_count != SAT) err_count <= err_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: drives mem_bist against a faulty single-port memory model and checks results against a pattern-level reference.
module tb_mem_bist;
   localparam int AW = 5;
   localparam int DW = 8;
   localparam int N = 32;
   localparam logic [7:0] SEED = 8'hA5;
`ifdef MEM_BIST_INV_PASS_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif
   localparam int SAT = 63;
   localparam int EXP_CYC = (PASSES == 2) ? 4 * N + 3 : 2 * N + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, done, pass, mem_wr, mem_rd;
   logic [AW:0] err_count;
   logic [AW-1:0] first_fail_addr, mem_addr;
   wire [DW-1:0] mem_data;

   logic [7:0] mem [N];
   logic [7:0] cmask [N];
   logic [7:0] rdata, smask, sval;
   logic rvalid, force_ff;
   int compared = 0, mismatched = 0, both_viol = 0;

   mem_bist #(.AWIDTH(AW), .DWIDTH(DW), .SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_fail_addr(first_fail_addr),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] corrupt(input logic [7:0] v, input int a);
      return force_ff ? 8'hFF : ((v & ~smask) | (sval & smask)) ^ cmask[a];
   endfunction

   function automatic logic [7:0] pat(input int a, input int p);
      logic [7:0] e;
      e = 8'(a) ^ SEED;
      return (p != 0) ? ~e : e;
   endfunction

   // registered-read memory: data appears the cycle after rd
   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr] <= mem_data;
      rvalid <= mem_rd;
      if (mem_rd) rdata <= corrupt(mem[mem_addr], int'(mem_addr));
      if (mem_wr && mem_rd) both_viol <= both_viol + 1;
   end
   assign mem_data = (rvalid && !mem_wr) ? rdata : 8'hzz;

   task automatic check(input string tag, input int got, input int exp);
      compared++;
      if (got != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_faults();
      smask = 8'h00;
      sval = 8'h00;
      force_ff = 1'b0;
      for (int a = 0; a < N; a++) cmask[a] = 8'h00;
   endtask

   task automatic model(output int errs, output int ffa);
      logic [7:0] e;
      errs = 0;
      ffa = 0;
      for (int p = 0; p < PASSES; p++)
         for (int a = 0; a < N; a++) begin
            e = pat(a, p);
            if (corrupt(e, a) != e) begin
               if (errs == 0) ffa = a;
               errs++;
            end
         end
      if (errs > SAT) errs = SAT;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int k = 1; k <= 400 && cyc == 0; k++) begin
         @(negedge clk);
         if (done) cyc = k;
      end
   endtask

   task automatic run(input bit hold, output int cyc);
      @(negedge clk) start = 1'b1;
      @(negedge clk) if (!hold) start = 1'b0;
      check("busy_rise", busy, 1);
      check("done_clr", done, 0);
      wait_done(cyc);
   endtask

   task automatic verify(input string tag);
      int cyc, errs, ffa, bad;
      model(errs, ffa);
      run(1'b0, cyc);
      check({tag, "_cyc"}, cyc, EXP_CYC);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err"}, err_count, errs);
      check({tag, "_ffa"}, first_fail_addr, ffa);
      check({tag, "_pass"}, pass, errs == 0);
      bad = 0;
      for (int a = 0; a < N; a++) if (mem[a] != pat(a, PASSES - 1)) bad++;
      check({tag, "_mem"}, bad, 0);
   endtask

   initial begin
      int cyc;
      clear_faults();
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", err_count, 0);
      check("rst_ffa", first_fail_addr, 0);
      check("rst_wr", mem_wr, 0);
      check("rst_rd", mem_rd, 0);
      check("rst_addr", mem_addr, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      verify("ideal");
      check("ideal_loc3", mem[3], (PASSES == 2) ? 8'h59 : 8'hA6);

      smask = 8'h01;
      verify("stuck0");
      check("stuck0_err_k", err_count, 16 * PASSES);
      clear_faults();

      cmask[31] = 8'h10;
      verify("last");
      check("last_ffa_k", first_fail_addr, 31);
      check("last_err_k", err_count, PASSES);
      clear_faults();

      force_ff = 1'b1;
      verify("allff");
      check("allff_err_k", err_count, (PASSES == 2) ? 63 : 32);
      clear_faults();

      run(1'b1, cyc);
      check("hold_cyc", cyc, EXP_CYC);
      check("hold_pass", pass, 1);
      @(negedge clk);
      check("hold_restart_busy", busy, 1);
      check("hold_restart_done", done, 0);
      start = 1'b0;
      wait_done(cyc);
      check("hold_cyc2", cyc, EXP_CYC);

      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_wr_active", mem_wr, 1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_err", err_count, 0);
      check("abort_wr", mem_wr, 0);
      check("abort_rd", mem_rd, 0);
      check("abort_addr", mem_addr, 0);
      @(negedge clk) rst_n = 1'b1;
      verify("post_abort");

      for (int it = 0; it < 8; it++) begin
         clear_faults();
         if ($urandom_range(0, 1) == 1) begin
            smask = 8'h01 << $urandom_range(0, 7);
            sval = 8'($urandom);
         end
         for (int j = $urandom_range(0, 3); j > 0; j--)
            cmask[$urandom_range(0, N - 1)] = 8'($urandom_range(1, 255));
         repeat ($urandom_range(0, 5)) @(negedge clk);
         verify($sformatf("rnd%0d", it));
      end

      check("wr_rd_exclusive", both_viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
